// File: rtl/sprite_line_renderer_pkg.sv
// Shared definitions for the sprite line renderer.
// Object entry layout, per-sprite geometry and the line-fetch FSM encoding.
package sprite_line_renderer_pkg;

  // Object table entry: byte0 = x, byte1 = y, byte2[2:0] = bitmap index,
  // byte3 = {enable, hflip, colour[5:0]}.
  localparam int OBJ_BYTES       = 4;
  localparam int ROWS_PER_SPRITE = 8;
  localparam int EN_BIT          = 7;
  localparam int FLIP_BIT        = 6;
  localparam int COLOUR_W        = 6;
  localparam int IDX_W           = 3;
  localparam int OBJ_LAST_K      = OBJ_BYTES;  // extra cycle to capture byte3

  typedef enum logic [2:0] {
    IDLE,
    OBJ_RD,
    HIT,
    BMP_RD,
    BMP_CAP
  } state_t;

endpackage

// File: rtl/sprite_line_renderer_slot.sv
// sprite_slot: one render slot of the sprite line renderer.
// Holds a fetched bitmap row with its x, colour and hflip, and reports
// whether the current pixel is covered by an opaque sprite pixel.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset (valid bit only)
//   clr_i               invalidate the slot
//   load_i              capture row/x/colour/hflip and mark valid
//   row_i, x_i, colour_i, hflip_i   slot contents
//   pix_x_i             current screen pixel x
//   opaque_o            slot is valid and pix_x hits a set bitmap bit
//   colour_o            slot colour {B,G,R}
module sprite_slot
  import sprite_line_renderer_pkg::*;
#(
  parameter int SCALE_SHIFT = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [7:0]          row_i,
  input  logic [7:0]          x_i,
  input  logic [COLOUR_W-1:0] colour_i,
  input  logic                hflip_i,
  input  logic [9:0]          pix_x_i,
  output logic                opaque_o,
  output logic [COLOUR_W-1:0] colour_o
);

  logic                valid_q;
  logic [7:0]          row_q;
  logic [7:0]          x_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                hflip_q;

  logic [10:0] dx;
  logic        in_range;
  logic [2:0]  col;
  logic [2:0]  col_eff;

  // Clear takes precedence over a load landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      row_q    <= row_i;
      x_q      <= x_i;
      colour_q <= colour_i;
      hflip_q  <= hflip_i;
    end
  end

  // pix_x left of the sprite wraps to a large 11-bit value, so one unsigned
  // compare covers both 0 <= dx and dx < span.
  assign dx       = 11'(pix_x_i) - (11'(x_q) << SCALE_SHIFT);
  assign in_range = dx < 11'(ROWS_PER_SPRITE << SCALE_SHIFT);
  assign col      = 3'(dx >> SCALE_SHIFT);
  assign col_eff  = hflip_q ? (3'd7 - col) : col;
  assign opaque_o = valid_q && in_range && row_q[3'd7 - col_eff];
  assign colour_o = colour_q;

endmodule

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: per-line sprite fetch and pixel compositing.
// On line_start it walks the object table, finds sprites crossing line_y,
// fetches one bitmap row per hit into a slot, then overlays the lowest-index
// opaque slot pixel on bg_rgb with one cycle of latency.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   line_start, line_y    begin (or restart) a fetch for line line_y
//   pix_x, visible, bg_rgb  render-side pixel stream
//   obj_addr / obj_data   object table read port (1-cycle latency)
//   bmp_addr / bmp_data   bitmap read port (1-cycle latency)
//   rgb_out               registered composited colour
//   busy                  line fetch in progress
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
#(
  parameter int MAX_SPRITES  = 4,
  parameter int BITMAP_BYTES = 47,
  parameter int SCALE_SHIFT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic [9:0] line_y,
  input  logic [9:0] pix_x,
  input  logic       visible,
  input  logic [5:0] bg_rgb,
  output logic [5:0] obj_addr,
  input  logic [7:0] obj_data,
  output logic [5:0] bmp_addr,
  input  logic [7:0] bmp_data,
  output logic [5:0] rgb_out,
  output logic       busy
);

  localparam int SW   = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;
  localparam int SPAN = ROWS_PER_SPRITE << SCALE_SHIFT;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      k_q, k_d;
  logic            busy_q, busy_d;
  logic [9:0]      ly_q, ly_d;
  logic [5:0]      bmp_addr_q, bmp_addr_d;
  logic [5:0]      rgb_q, rgb_d;

  logic [7:0]       ox_q, oy_q, oattr_q;
  logic [IDX_W-1:0] oidx_q;

  logic        clr_all, load;
  logic [7:0]  load_row;
  logic [10:0] y4, ly11;
  logic        hit, in_bmp;
  logic [2:0]  row;
  logic [5:0]  row_addr;

  logic                unused_idx_hi;
  logic [MAX_SPRITES-1:0] opaque;
  logic [COLOUR_W-1:0]    slot_col [MAX_SPRITES];

  // Upper bits of the index byte carry no meaning.
  assign unused_idx_hi = ^obj_data[7:IDX_W];

  assign y4       = 11'(oy_q) << SCALE_SHIFT;
  assign ly11     = 11'(ly_q);
  assign hit      = oattr_q[EN_BIT] && (ly11 >= y4) && (ly11 < y4 + 11'(SPAN));
  assign row      = 3'((ly11 - y4) >> SCALE_SHIFT);
  assign row_addr = {oidx_q, row};
  assign in_bmp   = int'(row_addr) < BITMAP_BYTES;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      ly_q       <= '0;
      bmp_addr_q <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      ly_q       <= ly_d;
      bmp_addr_q <= bmp_addr_d;
      rgb_q      <= rgb_d;
    end
  end

  // Byte k-1 of the entry arrives while k is on the address counter.
  always_ff @(posedge clk) begin
    if (state_q == OBJ_RD) begin
      case (k_q)
        3'd1:    ox_q    <= obj_data;
        3'd2:    oy_q    <= obj_data;
        3'd3:    oidx_q  <= obj_data[IDX_W-1:0];
        3'd4:    oattr_q <= obj_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    k_d        = k_q;
    busy_d     = busy_q;
    ly_d       = ly_q;
    bmp_addr_d = bmp_addr_q;
    clr_all    = 1'b0;
    load       = 1'b0;
    load_row   = bmp_data;
    if (line_start) begin
      // Also aborts a fetch in progress.
      ly_d    = line_y;
      clr_all = 1'b1;
      s_d     = '0;
      k_d     = '0;
      busy_d  = 1'b1;
      state_d = OBJ_RD;
    end else begin
      case (state_q)
        OBJ_RD: begin
          k_d = k_q + 3'd1;
          if (k_q == 3'(OBJ_LAST_K)) begin
            k_d     = '0;
            state_d = HIT;
          end
        end
        HIT: begin
          if (hit && in_bmp) begin
            bmp_addr_d = row_addr;
            state_d    = BMP_RD;
          end else begin
            // A hit whose row lies outside the bitmap becomes a valid,
            // fully transparent slot; a miss stays cleared.
            load     = hit;
            load_row = '0;
            state_d  = OBJ_RD;
          end
        end
        BMP_RD:  state_d = BMP_CAP;
        BMP_CAP: begin
          load    = 1'b1;
          state_d = OBJ_RD;
        end
        default: ;
      endcase
      // Advance to the next sprite after the slot decision.
      if (state_d == OBJ_RD && state_q != OBJ_RD) begin
        if (s_q == SW'(MAX_SPRITES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < MAX_SPRITES; i++) begin : g_slot
    sprite_slot #(.SCALE_SHIFT(SCALE_SHIFT)) u_slot (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (clr_all),
      .load_i   (load && (s_q == SW'(i))),
      .row_i    (load_row),
      .x_i      (ox_q),
      .colour_i (oattr_q[COLOUR_W-1:0]),
      .hflip_i  (oattr_q[FLIP_BIT]),
      .pix_x_i  (pix_x),
      .opaque_o (opaque[i]),
      .colour_o (slot_col[i])
    );
  end

  // Walk from the highest index down so the lowest opaque slot wins.
  always_comb begin
    rgb_d = bg_rgb;
    for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_d = slot_col[i];
    end
    if (!visible) rgb_d = '0;
  end

  assign obj_addr = 6'({s_q, k_q[1:0]});
  assign bmp_addr = bmp_addr_q;
  assign rgb_out  = rgb_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;

  localparam int NSPR = 4;
  localparam int BMPB = 47;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_start = 1'b0;
  logic [9:0] line_y = '0;
  logic [9:0] pix_x = '0;
  logic       visible = 1'b0;
  logic [5:0] bg_rgb = '0;
  logic [5:0] obj_addr;
  logic [7:0] obj_data = '0;
  logic [5:0] bmp_addr;
  logic [7:0] bmp_data = '0;
  logic [5:0] rgb_out;
  logic       busy;

  logic [7:0] obj_mem [64];
  logic [7:0] bmp_mem [64];
  logic [5:0] cap [128];

  int  ntests = 0;
  int  nfail  = 0;
  int  m_ly   = 0;
  bit  m_ok   = 1'b0;
  bit  bmp_bad = 1'b0;

  sprite_line_renderer #(.MAX_SPRITES(NSPR), .BITMAP_BYTES(BMPB), .SCALE_SHIFT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_y     (line_y),
    .pix_x      (pix_x),
    .visible    (visible),
    .bg_rgb     (bg_rgb),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .bmp_addr   (bmp_addr),
    .bmp_data   (bmp_data),
    .rgb_out    (rgb_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    obj_data <= obj_mem[obj_addr];
    bmp_data <= bmp_mem[bmp_addr];
  end

  always @(negedge clk) begin
    if (int'(bmp_addr) >= BMPB) bmp_bad <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] bgc(input int px);
    return 6'(px * 5 + 1);
  endfunction

  // Row address of sprite i on line ly, or -1 if the sprite misses the line.
  function automatic int model_row_addr(input int i, input int ly);
    int y4, attr;
    attr = int'(obj_mem[4*i+3]);
    y4   = int'(obj_mem[4*i+1]) * 4;
    if (attr < 128) return -1;
    if (ly < y4 || ly >= y4 + 32) return -1;
    return (int'(obj_mem[4*i+2]) % 8) * 8 + (ly - y4) / 4;
  endfunction

  function automatic int model_busy(input int ly);
    int c = 0;
    int ra;
    for (int i = 0; i < NSPR; i++) begin
      ra = model_row_addr(i, ly);
      c += (ra >= 0 && ra < BMPB) ? 8 : 6;
    end
    return c;
  endfunction

  function automatic logic [5:0] model_rgb(input int px, input bit vis, input logic [5:0] bg);
    int ra, dx, col;
    logic [7:0] attr, bits;
    if (!vis) return 6'd0;
    if (!m_ok) return bg;
    for (int i = 0; i < NSPR; i++) begin
      ra = model_row_addr(i, m_ly);
      if (ra < 0 || ra >= BMPB) continue;
      dx = px - int'(obj_mem[4*i]) * 4;
      if (dx < 0 || dx >= 32) continue;
      attr = obj_mem[4*i+3];
      col  = dx / 4;
      if (attr[6]) col = 7 - col;
      bits = bmp_mem[ra];
      if (bits[7-col]) return attr[5:0];
    end
    return bg;
  endfunction

  task automatic clear_tables();
    for (int i = 0; i < 64; i++) begin
      obj_mem[i] = 8'h00;
      bmp_mem[i] = 8'h00;
    end
    bmp_mem[56] = 8'hFF;
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int idx, input int attr);
    obj_mem[4*i]   = 8'(x);
    obj_mem[4*i+1] = 8'(y);
    obj_mem[4*i+2] = 8'(idx);
    obj_mem[4*i+3] = 8'(attr);
  endtask

  task automatic run_line(input int ly, input int lit_busy);
    int cnt, exp;
    exp = model_busy(ly);
    @(negedge clk);
    line_y     = 10'(ly);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, exp);
    if (lit_busy >= 0) check("busy_cycles_literal", cnt, lit_busy);
    m_ly = ly;
    m_ok = 1'b1;
  endtask

  // Each pixel is driven at one negedge and its output checked at the next.
  task automatic sweep(input int lo, input int hi, input bit vis);
    logic [5:0] exp_prev;
    exp_prev = '0;
    for (int px = lo; px <= hi + 1; px++) begin
      @(negedge clk);
      if (px > lo) begin
        check($sformatf("rgb@%0d", px - 1), int'(rgb_out), int'(exp_prev));
        cap[px-1] = rgb_out;
      end
      if (px <= hi) begin
        pix_x    = 10'(px);
        visible  = vis;
        bg_rgb   = bgc(px);
        exp_prev = model_rgb(px, vis, bgc(px));
      end
    end
    visible = 1'b0;
  endtask

  initial begin
    clear_tables();
    repeat (2) @(negedge clk);
    check("reset_rgb", int'(rgb_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_obj_addr", int'(obj_addr), 0);
    check("reset_bmp_addr", int'(bmp_addr), 0);
    reset = 1'b0;
    m_ok  = 1'b0;
    sweep(30, 80, 1'b1);

    // Single sprite, row 0x81: edge pixels only.
    set_obj(0, 10, 5, 0, 8'h80 | 8'h30);
    bmp_mem[0] = 8'h81;
    run_line(20, 26);
    sweep(30, 80, 1'b1);
    check("t1_px40", int'(cap[40]), 8'h30);
    check("t1_px43", int'(cap[43]), 8'h30);
    check("t1_px39", int'(cap[39]), int'(bgc(39)));
    check("t1_px44", int'(cap[44]), int'(bgc(44)));
    check("t1_px67", int'(cap[67]), int'(bgc(67)));
    check("t1_px68", int'(cap[68]), 8'h30);
    check("t1_px71", int'(cap[71]), 8'h30);
    check("t1_px72", int'(cap[72]), int'(bgc(72)));

    // Row 0xC0 without and with hflip.
    bmp_mem[0] = 8'hC0;
    run_line(20, 26);
    sweep(30, 80, 1'b1);
    check("t2_px47", int'(cap[47]), 8'h30);
    check("t2_px48", int'(cap[48]), int'(bgc(48)));
    set_obj(0, 10, 5, 0, 8'hC0 | 8'h30);
    run_line(20, 26);
    sweep(30, 80, 1'b1);
    check("t2f_px40", int'(cap[40]), int'(bgc(40)));
    check("t2f_px63", int'(cap[63]), int'(bgc(63)));
    check("t2f_px64", int'(cap[64]), 8'h30);

    // Overlap: slot 0 wins.
    clear_tables();
    set_obj(0, 10, 5, 0, 8'h80 | 8'h03);
    set_obj(1, 10, 5, 1, 8'h80 | 8'h0C);
    bmp_mem[0] = 8'hFF;
    bmp_mem[8] = 8'hFF;
    run_line(20, 28);
    sweep(30, 80, 1'b1);
    check("t3_px40", int'(cap[40]), 8'h03);
    check("t3_px71", int'(cap[71]), 8'h03);
    check("t3_px72", int'(cap[72]), int'(bgc(72)));

    // Line just below the sprite, then disabled sprite, then blanking.
    clear_tables();
    set_obj(0, 10, 5, 0, 8'h80 | 8'h30);
    bmp_mem[0] = 8'hFF;
    bmp_mem[7] = 8'hFF;
    run_line(52, 24);
    sweep(30, 80, 1'b1);
    check("t4_below_px40", int'(cap[40]), int'(bgc(40)));
    set_obj(0, 10, 5, 0, 8'h30);
    run_line(20, 24);
    sweep(30, 80, 1'b1);
    check("t4_dis_px40", int'(cap[40]), int'(bgc(40)));
    set_obj(0, 10, 5, 0, 8'h80 | 8'h30);
    run_line(20, 26);
    sweep(30, 80, 1'b0);
    check("t4_blank_px50", int'(cap[50]), 0);

    // Bitmap index 7: row address 56 lies outside the bitmap.
    clear_tables();
    set_obj(0, 10, 5, 7, 8'h80 | 8'h30);
    run_line(20, 24);
    sweep(30, 80, 1'b1);
    check("t5_px40", int'(cap[40]), int'(bgc(40)));
    check("t5_no_oob_read", int'(bmp_bad), 0);

    // Restart mid-fetch with a new line.
    clear_tables();
    set_obj(0, 10, 5, 0, 8'h80 | 8'h30);
    set_obj(1, 20, 20, 1, 8'h80 | 8'h0C);
    bmp_mem[0] = 8'hFF;
    bmp_mem[9] = 8'hA5;
    @(negedge clk);
    line_y     = 10'd20;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (8) @(negedge clk);
    run_line(84, 26);
    sweep(30, 120, 1'b1);
    check("t6_px40", int'(cap[40]), int'(bgc(40)));
    check("t6_px80", int'(cap[80]), 8'h0C);
    check("t6_px84", int'(cap[84]), int'(bgc(84)));

    // Reset during a fetch after slot 0 has been loaded.
    @(negedge clk);
    line_y     = 10'd20;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    pix_x      = 10'd40;
    visible    = 1'b1;
    bg_rgb     = 6'h15;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t7_busy", int'(busy), 0);
    check("t7_rgb", int'(rgb_out), 0);
    reset   = 1'b0;
    visible = 1'b0;
    m_ok    = 1'b0;
    sweep(30, 80, 1'b1);
    check("t7_px40", int'(cap[40]), int'(bgc(40)));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Downstream of the sprite peripheral's active object table and bitmap RAM, and beside the background generator.
- On each line-start pulse in horizontal blank, it scans the object table for sprites that intersect the next scanline and fetches one 1bpp bitmap row per hit into slot registers.
- During the visible period it overlays the highest-priority opaque sprite pixel on the background colour and drives registered 6-bit RGB for uo_out.

Parameters:
- MAX_SPRITES, 4, number of object entries and render slots. Object table is 4*MAX_SPRITES bytes.
- BITMAP_BYTES, 47, size of the bitmap region in bytes. Reads at or beyond this size are not issued.
- SCALE_SHIFT, 2, sprite pixel = 2^SCALE_SHIFT screen pixels. Object x/y coordinates are also multiplied by 2^SCALE_SHIFT.

Ports:
- clk  in  1  project clock.
- reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse at start of horizontal blank.
- line_y  in  10  y of the line to be rendered next; sampled on line_start.
- pix_x  in  10  current pixel x.
- visible  in  1  active video.
- bg_rgb  in  6  background colour {B,G,R}, aligned with pix_x.
- obj_addr  out  6  object table byte address.
- obj_data  in  8  obj_addr contents, valid one cycle after obj_addr.
- bmp_addr  out  6  bitmap byte address, relative to the bitmap base.
- bmp_data  in  8  bmp_addr contents, valid one cycle after bmp_addr.
- rgb_out  out  6  composited colour, registered.
- busy  out  1  line fetch in progress.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: rgb_out=0, busy=0, obj_addr=0, bmp_addr=0, FSM in IDLE, all slot valid bits 0.
- Object entry i lives at bytes 4i..4i+3:
  - byte0 = x.
  - byte1 = y.
  - byte2[2:0] = bitmap index; byte2[7:3] ignored.
  - byte3[5:0] = colour {B,G,R}; byte3[6] = hflip; byte3[7] = enable.
- Bitmap row address = index*8 + row, where row = (line_y - (y<<SCALE_SHIFT)) >> SCALE_SHIFT, range 0..7. Byte bit7 is the leftmost pixel.
- FSM states: IDLE, OBJ_RD, HIT, BMP_RD, BMP_CAP.
  - IDLE, on line_start: latch line_y, clear all slot valid bits, set sprite counter s=0, busy=1, go to OBJ_RD.
  - OBJ_RD: 5 cycles. obj_addr = 4s+k for k=0..3; bytes captured on the following cycle.
  - HIT: hit = enable && line_y >= (y<<SCALE_SHIFT) && line_y < ((y+8)<<SCALE_SHIFT). Use 11-bit arithmetic, no wrap.
    - Hit with row address < BITMAP_BYTES: go to BMP_RD.
    - Hit with row address >= BITMAP_BYTES: slot s valid with row bits 0; next sprite.
    - Miss: slot s invalid; next sprite.
  - BMP_RD: drive bmp_addr. BMP_CAP: store row bits, x, colour and hflip into slot s; set valid.
  - Next sprite: s+1. After s=MAX_SPRITES-1, return to IDLE and set busy=0.
- Fetch time: 8 cycles per hit, 6 per miss. Worst case 8*MAX_SPRITES cycles.
- line_start while busy: abort the current fetch, clear all slots, restart with the new line_y.
- Render, per slot:
  - dx = pix_x - (x<<SCALE_SHIFT).
  - In range when 0 <= dx < 8<<SCALE_SHIFT.
  - col = dx>>SCALE_SHIFT, mirrored to 7-col when hflip.
  - Opaque when row bit[7-col] = 1.
- Compositing: lowest slot index wins. Each cycle, rgb_out <= !visible ? 0 : (any opaque ? slot colour : bg_rgb).
- Latency: exactly 1 cycle from pix_x/visible/bg_rgb to rgb_out.
- Rendering uses whatever slots are valid. A fetch still in progress during visible shows only the completed slots.

Decomposition:
- Shared package holds:
  - entry field offsets and bit positions (EN_BIT=7, FLIP_BIT=6, COLOUR width 6);
  - OBJ_BYTES=4, ROWS_PER_SPRITE=8;
  - FSM state encoding.
- One natural sub-module: sprite_slot. It holds one slot's registers and computes in_range/opaque from pix_x. It is instantiated MAX_SPRITES times, and the top module holds the FSM and the priority mux.

Test Plan:
- Sprite 0 = {x=10, y=5, idx=0, colour=0x30, en}, bitmap row0=0x81; line_start with line_y=20, then sweep visible:
  - pixels 40..43 and 68..71 give rgb_out=0x30, one cycle late;
  - pixels 44..67 give bg_rgb;
  - busy high for 8+3*6=26 cycles.
- Same sprite with row0=0xC0: hflip=0 gives colour at 40..47; hflip=1 gives colour at 64..71.
- Sprites 0 and 1 overlap at x=10, colours 0x03 and 0x0C, both rows 0xFF: rgb_out=0x03 across 40..71.
- line_y=52 (just below y=5 sprite, last row at 51) and enable=0 cases: no slot valid, rgb_out=bg_rgb everywhere. With visible=0, rgb_out=0.
- idx=7 with row 0: address 56 >= 47, no bmp read issued, sprite transparent. Second line_start 10 cycles into a fetch: fetch restarts, slots cleared, final slots match the new line_y only.
- reset asserted mid-fetch: next cycle busy=0, rgb_out=0, all slots invalid.
